// File: rtl/alu4_serial.sv
// ---------------------------------------------------------------------------
// alu4_serial -- bit-serial ALU engine.
//
// Takes one operand pair and an opcode through a valid/ready handshake,
// computes the result one bit per clock (LSB first) through a single 1-bit
// logic/full-adder cell, then holds result and flags until the consumer
// takes them. Trades latency (WIDTH+2 cycle issue interval) for area.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair + opcode valid
//   in_ready   engine idle and able to accept
//   a, b       operands (sampled on accept)
//   op         000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (A-B), others reserved
//   out_valid  result/flags valid (HOLD)
//   out_ready  consumer takes the result
//   out        result
//   carry      ADD carry-out / SUB no-borrow; 0 for logic and reserved ops
//   zero       result is all zeros
// ---------------------------------------------------------------------------

// One-bit slice shared by every bit position. SUB inverts B here, so the
// A + ~B + 1 form only needs the carry preset to 1 at accept time.
module alu4_serial_cell (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [2:0] op_i,
  output logic       r_o,
  output logic       c_o
);
  logic b_eff, p;

  assign b_eff = (op_i == 3'b100) ? ~b_i : b_i;
  assign p     = a_i ^ b_eff;

  always_comb begin
    r_o = 1'b0;
    c_o = 1'b0;
    unique case (op_i)
      3'b000: r_o = a_i & b_i;
      3'b001: r_o = a_i | b_i;
      3'b010: r_o = a_i ^ b_i;
      3'b011,
      3'b100: begin
        r_o = p ^ c_i;
        c_o = (a_i & b_eff) | (c_i & p);
      end
      default: ; // reserved ops: result bit and carry stay 0
    endcase
  end
endmodule

module alu4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [2:0]       op_q, op_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             bit_r, bit_c, arith;
  logic [WIDTH-1:0] res_nxt;

  alu4_serial_cell u_cell (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (cy_q),
    .op_i (op_q),
    .r_o  (bit_r),
    .c_o  (bit_c)
  );

  assign arith   = (op_q == 3'b011) || (op_q == 3'b100);
  // Result fills from the MSB side so after WIDTH shifts bit 0 lands in [0].
  assign res_nxt = {bit_r, res_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    cy_d     = cy_q;
    out_d    = out_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          op_d     = op;
          cnt_d    = '0;
          res_sh_d = '0;
          cy_d     = (op == 3'b100);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_nxt;
        if (arith) cy_d = bit_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d   = res_nxt;
          carry_d = arith ? bit_c : 1'b0;
          zero_d  = (res_nxt == '0);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      cy_q     <= 1'b0;
      out_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      cy_q     <= cy_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out       = out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
endmodule

// File: doc/alu4_serial.md
# alu4_serial

Bit-serial 4-bit ALU engine: the sequential counterpart of the parallel gate-level logic slices (OR/AND/XOR/adder). It accepts one operand pair plus opcode through a valid/ready handshake. It computes the result one bit per clock, LSB first, through a single 1-bit logic/full-adder cell. It then holds the result and flags until the consumer takes them. It sits between the operand/opcode source and the result register file, where area matters more than latency.

## Interface
- WIDTH, 4, operand and result width in bits; bit counter is clog2(WIDTH) bits.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and opcode valid.
- in_ready  output  1  engine can accept; high only in IDLE.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- op  input  3  opcode, sampled on accept.
  - 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (A−B).
  - 101–111 reserved.
- out_valid  output  1  result and flags valid; high only in HOLD.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  result.
- carry  output  1  ADD carry-out; SUB no-borrow (1 when A ≥ B unsigned); 0 for logic and reserved ops.
- zero  output  1  1 when out == 0.

## Operation
- State machine IDLE → RUN → HOLD → IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid=1 at a rising edge.
  - On accept, latch a, b and op into shift registers, clear the bit counter, and preset the serial carry: 1 for SUB, 0 otherwise.
  - Go to RUN.
- RUN:
  - in_ready=0, out_valid=0. in_valid and operand inputs are ignored.
  - Each edge computes bit i from a_sh[0], b_sh[0] and the serial carry.
  - SUB uses ~b_sh[0]. Logic ops ignore the carry. Reserved ops produce 0.
  - Shift the result bit into the result register from the MSB side. Shift the operands right. Update the carry (add/sub only).
  - After the WIDTH-th RUN edge, load out, carry and zero from the completed result and go to HOLD.
- HOLD:
  - out_valid=1; out, carry and zero are held stable.
  - An edge with out_ready=1 completes the transfer and goes to IDLE.
  - out, carry and zero keep their values in IDLE until the next result loads.
- Arithmetic is modulo 2^WIDTH; no overflow flag.
- SUB is computed as A + ~B + 1.
- Reserved ops: out=0, carry=0, zero=1.

## Timing
- Reset (rst=1 at an edge):
  - State goes to IDLE and the counter clears.
  - out=0, carry=0, zero=0, out_valid=0.
  - in_ready=1 from the first cycle after the reset edge.
- Reset has priority over every other event. Reset during RUN or HOLD aborts the operation; no result is ever presented.
- Latency: accept edge in cycle 0, RUN in cycles 1..WIDTH, out_valid=1 from cycle WIDTH+1 (cycle 5 for WIDTH=4).
- With out_ready held at 1, HOLD lasts exactly one cycle; in_ready returns at cycle WIDTH+2.
- Minimum issue interval is WIDTH+2 cycles.
- No accept in HOLD, even if out_ready=1 in the same cycle.
- Backpressure: HOLD persists indefinitely while out_ready=0, with out, carry and zero unchanged.
- out_ready outside HOLD has no effect.
- in_valid may be held continuously. Exactly one accept occurs per IDLE visit.

## Test plan
- OR, a=1010, b=0101, op=001, accepted in cycle 0 -> out_valid first high in cycle 5; out=1111, carry=0, zero=0; in_ready=0 in cycles 1–5.
- ADD, a=1111, b=0001 -> out=0000, carry=1, zero=1. ADD, a=0110, b=0111 -> out=1101, carry=0, zero=0.
- SUB, a=0011, b=0101 -> out=1110, carry=0. SUB, a=0101, b=0011 -> out=0010, carry=1. SUB, a=1001, b=1001 -> out=0000, carry=1, zero=1.
- Backpressure and ignored input:
  - Stimulus: AND a=1100, b=1010; out_ready=0 for cycles 5–8, 1 in cycle 9; in_valid held at 1 with new operands throughout.
  - Response: out=1000 stable in cycles 5–9; in_ready=1 in cycle 10; the second operation is accepted in cycle 10, not earlier.
- Reset mid-operation:
  - Stimulus: XOR accepted in cycle 0; rst=1 in cycle 2.
  - Response: out_valid never rises; out=0, zero=0; in_ready=1 in cycle 3.
  - Follow-up: XOR a=1100, b=1010 -> out=0110 after 5 cycles.
- Reserved op=111, a=1111, b=1111 -> out=0000, carry=0, zero=1, same latency as the other ops.
